// File: rtl/capture_ctrl_if.sv
// Capture RAM write port shared by the acquisition sequencer (master) and the sample buffer (slave).
interface capture_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/capture_ctrl.sv
// Oscilloscope acquisition sequencer: paced sampling into a circular buffer with pre-trigger
// history, level/edge or forced trigger, then a fixed post-trigger fill and stop.
module capture_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4,
    parameter int DIV_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     force_trig,
    input  logic                     trig_edge,
    input  logic signed [WIDTH-1:0]  trig_level,
    input  logic        [ADDR_W-1:0] pre_count,
    input  logic        [DIV_W-1:0]  div,
    input  logic signed [WIDTH-1:0]  adc_data,
    capture_ctrl_if.master           wr,
    output logic        [ADDR_W-1:0] trig_addr,
    output logic                     busy,
    output logic                     done,
    output logic        [2:0]        state
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PRE   = 3'd1;
    localparam logic [2:0] ARMED = 3'd2;
    localparam logic [2:0] POST  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [2:0]               state_q;
    logic [DIV_W-1:0]         div_q;
    logic [DIV_W-1:0]         div_cnt;
    logic [DIV_W-1:0]         div_last;
    logic [ADDR_W-1:0]        pre_q;
    logic [ADDR_W-1:0]        fill_cnt;
    logic [ADDR_W-1:0]        post_rem;
    logic [ADDR_W-1:0]        wr_ptr;
    logic                     edge_q;
    logic signed [WIDTH-1:0]  level_q;
    logic signed [WIDTH-1:0]  prev;
    logic                     prev_valid;
    logic                     running;
    logic                     tick;
    logic                     start;
    logic                     rising;
    logic                     falling;
    logic                     hit;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        div_last = (div_q == '0) ? '0 : div_q - DIV_ONE;
        running  = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
        tick     = running && (div_cnt == div_last);
        start    = arm && ((state_q == IDLE) || (state_q == DONE));
        rising   = (prev < level_q) && (adc_data >= level_q);
        falling  = (prev > level_q) && (adc_data <= level_q);
        hit      = force_trig || (prev_valid && (edge_q ? falling : rising));
        busy     = running;
        done     = (state_q == DONE);
        state    = state_q;
    end

    // NOTE: sequential state uses non-blocking assignments only; wr_en defaults low so it is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            div_cnt    <= '0;
            pre_q      <= '0;
            fill_cnt   <= '0;
            post_rem   <= '0;
            wr_ptr     <= '0;
            edge_q     <= 1'b0;
            level_q    <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            trig_addr  <= '0;
            wr.wr_en   <= 1'b0;
            wr.wr_addr <= '0;
            wr.wr_data <= '0;
        end else begin
            wr.wr_en <= 1'b0;
            if (abort) begin
                state_q    <= IDLE;
                div_cnt    <= '0;
                prev_valid <= 1'b0;
                trig_addr  <= '0;
            end else if (start) begin
                pre_q      <= pre_count;
                div_q      <= div;
                edge_q     <= trig_edge;
                level_q    <= trig_level;
                div_cnt    <= '0;
                fill_cnt   <= '0;
                wr_ptr     <= '0;
                prev_valid <= 1'b0;
                state_q    <= (pre_count != '0) ? PRE : ARMED;
            end else if (running) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
                if (tick) begin
                    wr.wr_en   <= 1'b1;
                    wr.wr_addr <= wr_ptr;
                    wr.wr_data <= adc_data;
                    wr_ptr     <= wr_ptr + ADDR_ONE;
                    prev       <= adc_data;
                    prev_valid <= 1'b1;
                    case (state_q)
                        PRE: begin
                            fill_cnt <= fill_cnt + ADDR_ONE;
                            if (fill_cnt + ADDR_ONE == pre_q) state_q <= ARMED;
                        end
                        ARMED: begin
                            if (hit) begin
                                // Post-trigger length fills the rest of the buffer: DEPTH-1-pre.
                                trig_addr <= wr_ptr;
                                post_rem  <= ~pre_q;
                                state_q   <= (&pre_q) ? DONE : POST;
                            end
                        end
                        POST: begin
                            post_rem <= post_rem - ADDR_ONE;
                            if (post_rem == ADDR_ONE) state_q <= DONE;
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: expected RAM writes are queued as stimulus is planned and
// popped by a write monitor; state/handshake outputs are checked inline.
module tb_capture_ctrl;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;
    localparam int DIV_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    arm;
    logic                    abort;
    logic                    force_trig;
    logic                    trig_edge;
    logic signed [WIDTH-1:0] trig_level;
    logic [ADDR_W-1:0]       pre_count;
    logic [DIV_W-1:0]        div;
    logic signed [WIDTH-1:0] adc_data;
    logic [ADDR_W-1:0]       trig_addr;
    logic                    busy;
    logic                    done;
    logic [2:0]              state;

    capture_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) wr_bus ();

    capture_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .abort      (abort),
        .force_trig (force_trig),
        .trig_edge  (trig_edge),
        .trig_level (trig_level),
        .pre_count  (pre_count),
        .div        (div),
        .adc_data   (adc_data),
        .wr         (wr_bus.master),
        .trig_addr  (trig_addr),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  errors   = 0;
    int  wr_count = 0;
    int  wc0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int addr, input int data);
        wr_t e;
        e.addr = ADDR_W'(addr);
        e.data = WIDTH'(data);
        exp_q.push_back(e);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step(1);
        arm = 1'b0;
    endtask

    // Write monitor samples on the falling edge, half a cycle away from the DUT's update.
    always @(negedge clk) begin
        if (wr_bus.wr_en === 1'b1) begin
            wr_t e;
            wr_count++;
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_bus.wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_bus.wr_data), 32'(e.data));
            end
        end
    end

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            arm        = 1'($urandom);
            abort      = 1'($urandom);
            force_trig = 1'($urandom);
            trig_edge  = 1'($urandom);
            trig_level = WIDTH'($urandom);
            pre_count  = ADDR_W'($urandom);
            div        = DIV_W'($urandom);
            adc_data   = WIDTH'($urandom);
            step(1);
        end
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_en", 32'(wr_bus.wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_bus.wr_data), 32'd0);
        check("rst_trig_addr", 32'(trig_addr), 32'd0);
        arm = 0; abort = 0; force_trig = 0; trig_edge = 0;
        trig_level = 0; pre_count = 0; div = 0; adc_data = 0;
        rst = 1'b0;
        step(1);
        check("idle_state", 32'(state), 32'd0);

        // Rising trigger on a ramp from -10, pre_count=4
        pre_count = 4; div = 0; trig_level = 0; trig_edge = 0;
        for (int k = 1; k <= 22; k++) push((k - 1) % DEPTH, -11 + k);
        wc0 = wr_count;
        do_arm();
        check("rise_state_pre", 32'(state), 32'd1);
        check("rise_busy", 32'(busy), 32'd1);
        for (int j = 1; j <= 40 && done !== 1'b1; j++) begin
            adc_data = WIDTH'(-11 + j);
            step(1);
        end
        check("rise_done", 32'(done), 32'd1);
        step(1);
        check("rise_trig_addr", 32'(trig_addr), 32'd10);
        check("rise_busy_off", 32'(busy), 32'd0);
        check("rise_wr_total", 32'(wr_count - wc0), 32'd22);
        check("rise_queue_empty", 32'(exp_q.size()), 32'd0);

        // Divider: div=3 gives one write every 3 cycles, first one 3 edges after the arm edge
        pre_count = 2; div = 3; trig_level = 8'sd100;
        push(0, 3); push(1, 6); push(2, 9); push(3, 12);
        do_arm();
        check("div_done_drop", 32'(done), 32'd0);
        for (int j = 1; j <= 12; j++) begin
            adc_data = WIDTH'(j);
            step(1);
            check("div_wr_en", 32'(wr_bus.wr_en), 32'((j % 3) == 0));
        end
        check("div_state_armed", 32'(state), 32'd2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("div_abort_state", 32'(state), 32'd0);
        step(1);
        check("div_queue_empty", 32'(exp_q.size()), 32'd0);

        // Forced trigger on the 7th ARMED tick with a constant input
        pre_count = 3; div = 0; trig_level = 0; trig_edge = 0; adc_data = 5;
        for (int k = 1; k <= 22; k++) push((k - 1) % DEPTH, 5);
        wc0 = wr_count;
        do_arm();
        for (int j = 1; j <= 40 && done !== 1'b1; j++) begin
            force_trig = (j == 10);
            step(1);
            if (j == 9) check("force_still_armed", 32'(state), 32'd2);
        end
        force_trig = 1'b0;
        check("force_done", 32'(done), 32'd1);
        step(1);
        check("force_trig_addr", 32'(trig_addr), 32'd9);
        check("force_wr_total", 32'(wr_count - wc0), 32'd22);
        check("force_queue_empty", 32'(exp_q.size()), 32'd0);

        // Falling edge, pre_count=0 goes straight to ARMED; input 3,2,1,0,...
        pre_count = 0; div = 0; trig_level = 0; trig_edge = 1;
        for (int k = 1; k <= 19; k++) push((k - 1) % DEPTH, 4 - k);
        wc0 = wr_count;
        do_arm();
        check("fall_state_armed", 32'(state), 32'd2);
        check("fall_done_drop", 32'(done), 32'd0);
        for (int j = 1; j <= 40 && done !== 1'b1; j++) begin
            adc_data = WIDTH'(4 - j);
            step(1);
        end
        check("fall_done", 32'(done), 32'd1);
        step(1);
        check("fall_trig_addr", 32'(trig_addr), 32'd3);
        check("fall_wr_total", 32'(wr_count - wc0), 32'd19);
        check("fall_queue_empty", 32'(exp_q.size()), 32'd0);

        // Abort in POST: writes stop at once, trig_addr cleared
        pre_count = 0; div = 0; trig_edge = 0; trig_level = 0; adc_data = 7;
        for (int k = 1; k <= 4; k++) push(k - 1, 7);
        force_trig = 1'b1;
        do_arm();
        step(1);
        force_trig = 1'b0;
        check("abort_in_post", 32'(state), 32'd3);
        step(3);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_wr_en", 32'(wr_bus.wr_en), 32'd0);
        check("abort_trig_addr", 32'(trig_addr), 32'd0);
        step(5);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

        // pre_count=15: rearm restarts at address 0, arm in ARMED ignored, trigger goes straight to DONE
        pre_count = 15; div = 0; trig_edge = 0; trig_level = 8'sd127;
        for (int k = 1; k <= 18; k++) push((k - 1) % DEPTH, k);
        wc0 = wr_count;
        do_arm();
        check("p15_state_pre", 32'(state), 32'd1);
        for (int j = 1; j <= 18; j++) begin
            adc_data   = WIDTH'(j);
            arm        = (j == 17);
            force_trig = (j == 18);
            step(1);
            if (j == 16) check("p15_state_armed", 32'(state), 32'd2);
            if (j == 17) check("p15_arm_ignored", 32'(state), 32'd2);
        end
        arm = 1'b0;
        force_trig = 1'b0;
        check("p15_state_done", 32'(state), 32'd4);
        check("p15_trig_addr", 32'(trig_addr), 32'd1);
        step(3);
        check("p15_wr_total", 32'(wr_count - wc0), 32'd18);
        check("p15_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
